// File: rtl/split_mem_pkg.sv
// Shared widths and payload types for the split-transaction memory responder.
package split_mem_pkg;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } resp_entry_t;
endpackage

// File: rtl/split_mem_responder_if.sv
// Host-side request/response bundle of the split-transaction memory interface.
interface split_mem_responder_if;
  import split_mem_pkg::*;

  logic              req;
  logic              ack;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              resp;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, resp, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/split_resp_delay_line.sv
// Fixed-depth shift register carrying read responses; only valid bits are reset.
module split_resp_delay_line
  import split_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  resp_entry_t       stage_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  always_comb begin
    stage_d[0] = '{valid: in_valid, data: in_data};
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = '{valid: valid_q[i-1], data: data_q[i-1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) valid_q[i] <= stage_d[i].valid;
    end
  end

  // Payload needs no reset: it is only observed alongside its valid bit.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= stage_d[i].data;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/split_mem_responder.sv
// Target-side memory model: byte-enabled writes, fixed-latency in-order reads,
// optional LFSR-driven ack throttling.
module split_mem_responder
  import split_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter string       INIT_FILE       = ""
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  split_mem_responder_if.slave host
);
  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;

  logic [7:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              stall_c, ack_c, rd_xfer_c, wr_xfer_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic              dl_out_valid;
  logic [DATA_W-1:0] dl_out_data;
  logic              unused_addr_c;

  assign idx_c         = host.addr[AW+1:2];
  assign unused_addr_c = ^{host.addr[ADDR_W-1:AW+2], host.addr[1:0]};

  // Ack is masked during reset so it drops the moment rst_ni falls.
  always_comb begin
    stall_c   = STALL_EN && (lfsr_q[1:0] == 2'b00);
    ack_c     = rst_ni && host.req && !stall_c &&
                (host.we || (outst_q < CNT_W'(MAX_OUTSTANDING)));
    wr_xfer_c = ack_c && host.we;
    rd_xfer_c = ack_c && !host.we;
    lfsr_d    = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    outst_d   = outst_q + CNT_W'(rd_xfer_c) - CNT_W'(dl_out_valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q  <= LFSR_SEED;
      outst_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      outst_q <= outst_d;
    end
  end

  // Memory survives reset so a bench can re-read contents afterwards.
  always_ff @(posedge clk_i) begin
    if (wr_xfer_c) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (host.be[i]) mem_q[idx_c][8*i +: 8] <= host.wdata[8*i +: 8];
      end
    end
  end

  split_resp_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_delay (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (rd_xfer_c),
    .in_data   (mem_q[idx_c]),
    .out_valid (dl_out_valid),
    .out_data  (dl_out_data)
  );

  assign host.ack   = ack_c;
  assign host.resp  = dl_out_valid;
  assign host.rdata = dl_out_valid ? dl_out_data : '0;
endmodule
